// File: rtl/ccip_c1tx_arbiter.sv
// rtl/ccip_c1tx_arbiter.sv - round-robin C1 Tx write arbiter with burst lock and registered output stage
module ccip_c1tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512
) (
  input  logic                        clk,
  input  logic                        SoftReset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [4*NUM_REQ-1:0]        req_type,
  input  logic [2*NUM_REQ-1:0]        req_cl_len,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]       req_mdata,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        c1TxAlmFull,
  output logic                        c1tx_valid,
  output logic [3:0]                  c1tx_type,
  output logic [1:0]                  c1tx_cl_len,
  output logic [1:0]                  c1tx_cl_num,
  output logic [ADDR_W-1:0]           c1tx_addr,
  output logic [15:0]                 c1tx_mdata,
  output logic [DATA_W-1:0]           c1tx_data,
  output logic [$clog2(NUM_REQ)-1:0]  c1tx_grant_id,
  output logic                        err_illegal,
  output logic [31:0]                 beat_count
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {ARB, LOCK} state_e;

  state_e            state_q;
  logic [IDW-1:0]    rr_ptr_q, lock_id_q;
  logic [1:0]        remaining_q, beat_idx_q;
  logic [3:0]        lock_type_q;
  logic [1:0]        lock_len_q;
  logic [ADDR_W-1:0] lock_addr_q;

  logic              valid_q, err_q;
  logic [3:0]        type_q;
  logic [1:0]        cl_len_q, cl_num_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       mdata_q;
  logic [DATA_W-1:0] data_q;
  logic [IDW-1:0]    grant_q;
  logic [31:0]       beat_count_q;

  logic [IDW:0]      sum;
  logic [IDW-1:0]    cand, arb_id, gnt_id, rr_ptr_d;
  logic              arb_found, can_go, accept;
  logic [3:0]        sel_type;
  logic [1:0]        sel_len, out_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_mdata;
  logic [DATA_W-1:0] sel_data;
  logic              single_beat, illegal;

  // Walk offsets high to low so the requester closest to rr_ptr wins last.
  always_comb begin
    arb_id    = rr_ptr_q;
    arb_found = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      cand = sum[IDW-1:0];
      if (req_valid[cand]) begin
        arb_id    = cand;
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_id    = (state_q == LOCK) ? lock_id_q : arb_id;
    can_go    = !SoftReset && !c1TxAlmFull && ((state_q == LOCK) || arb_found);
    req_ready = '0;
    sel_type  = '0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_mdata = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        req_ready[i] = can_go;
        sel_type     = req_type[i*4 +: 4];
        sel_len      = req_cl_len[i*2 +: 2];
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_mdata    = req_mdata[i*16 +: 16];
        sel_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
    accept      = |(req_valid & req_ready);
    single_beat = (sel_type == 4'd4) || (sel_type == 4'd6);
    illegal     = !(sel_type inside {4'd0, 4'd1, 4'd4, 4'd6}) || (sel_len == 2'd2);
    // For legal lengths 0/1/3 the beats-minus-one equals cl_len itself.
    out_len     = (illegal || single_beat) ? 2'd0 : sel_len;
    rr_ptr_d    = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      remaining_q  <= '0;
      beat_idx_q   <= '0;
      lock_type_q  <= '0;
      lock_len_q   <= '0;
      lock_addr_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      type_q       <= '0;
      cl_len_q     <= '0;
      cl_num_q     <= '0;
      addr_q       <= '0;
      mdata_q      <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      beat_count_q <= '0;
    end else begin
      valid_q <= accept;
      err_q   <= accept && (state_q == ARB) && illegal;
      if (accept) begin
        beat_count_q <= beat_count_q + 32'd1;
        grant_q      <= gnt_id;
        mdata_q      <= sel_mdata;
        data_q       <= sel_data;
        if (state_q == ARB) begin
          type_q      <= sel_type;
          cl_len_q    <= out_len;
          cl_num_q    <= 2'd0;
          addr_q      <= sel_addr;
          lock_id_q   <= gnt_id;
          lock_type_q <= sel_type;
          lock_len_q  <= out_len;
          lock_addr_q <= sel_addr;
          if (out_len != 2'd0) begin
            state_q     <= LOCK;
            remaining_q <= out_len;
            beat_idx_q  <= 2'd1;
          end else begin
            rr_ptr_q <= rr_ptr_d;
          end
        end else begin
          type_q      <= lock_type_q;
          cl_len_q    <= lock_len_q;
          cl_num_q    <= beat_idx_q;
          addr_q      <= lock_addr_q;
          beat_idx_q  <= beat_idx_q + 2'd1;
          remaining_q <= remaining_q - 2'd1;
          if (remaining_q == 2'd1) begin
            state_q  <= ARB;
            rr_ptr_q <= rr_ptr_d;
          end
        end
      end
    end
  end

  assign c1tx_valid    = valid_q;
  assign c1tx_type     = type_q;
  assign c1tx_cl_len   = cl_len_q;
  assign c1tx_cl_num   = cl_num_q;
  assign c1tx_addr     = addr_q;
  assign c1tx_mdata    = mdata_q;
  assign c1tx_data     = data_q;
  assign c1tx_grant_id = grant_q;
  assign err_illegal   = err_q;
  assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_ccip_c1tx_arbiter.sv
// tb/tb_ccip_c1tx_arbiter.sv - directed self-checking bench for ccip_c1tx_arbiter
module tb_ccip_c1tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 42;
  localparam int DATA_W  = 512;

  logic                       clk = 1'b0;
  logic                       SoftReset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [4*NUM_REQ-1:0]       req_type;
  logic [2*NUM_REQ-1:0]       req_cl_len;
  logic [ADDR_W*NUM_REQ-1:0]  req_addr;
  logic [16*NUM_REQ-1:0]      req_mdata;
  logic [DATA_W*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       c1TxAlmFull;
  logic                       c1tx_valid;
  logic [3:0]                 c1tx_type;
  logic [1:0]                 c1tx_cl_len;
  logic [1:0]                 c1tx_cl_num;
  logic [ADDR_W-1:0]          c1tx_addr;
  logic [15:0]                c1tx_mdata;
  logic [DATA_W-1:0]          c1tx_data;
  logic [1:0]                 c1tx_grant_id;
  logic                       err_illegal;
  logic [31:0]                beat_count;

  int checks = 0;
  int errors = 0;
  int gcount [NUM_REQ];

  ccip_c1tx_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .SoftReset(SoftReset),
    .req_valid(req_valid), .req_type(req_type), .req_cl_len(req_cl_len),
    .req_addr(req_addr), .req_mdata(req_mdata), .req_data(req_data),
    .req_ready(req_ready), .c1TxAlmFull(c1TxAlmFull),
    .c1tx_valid(c1tx_valid), .c1tx_type(c1tx_type), .c1tx_cl_len(c1tx_cl_len),
    .c1tx_cl_num(c1tx_cl_num), .c1tx_addr(c1tx_addr), .c1tx_mdata(c1tx_mdata),
    .c1tx_data(c1tx_data), .c1tx_grant_id(c1tx_grant_id),
    .err_illegal(err_illegal), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] t, input logic [1:0] len,
                         input logic [ADDR_W-1:0] a, input logic [15:0] md);
    req_valid[i]                  = 1'b1;
    req_type[i*4 +: 4]            = t;
    req_cl_len[i*2 +: 2]          = len;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_mdata[i*16 +: 16]         = md;
    req_data[i*DATA_W +: DATA_W]  = {8{48'h0, md}};
  endtask

  task automatic ready_is(input string tag, input logic [NUM_REQ-1:0] exp);
    #1;
    check(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic out_is(input string tag, input logic [1:0] gid, input logic [1:0] num,
                        input logic [ADDR_W-1:0] a);
    check({tag, "_valid"}, 64'(c1tx_valid), 64'd1);
    check({tag, "_gid"},   64'(c1tx_grant_id), 64'(gid));
    check({tag, "_num"},   64'(c1tx_cl_num), 64'(num));
    check({tag, "_addr"},  64'(c1tx_addr), 64'(a));
  endtask

  initial begin
    SoftReset   = 1'b1;
    c1TxAlmFull = 1'b0;
    req_valid = '0; req_type = '0; req_cl_len = '0;
    req_addr = '0; req_mdata = '0; req_data = '0;
    set_req(0, 4'd0, 2'd0, 42'h55, 16'h1);
    ready_is("rst_ready", 4'b0000);
    repeat (3) step();
    check("rst_valid", 64'(c1tx_valid), 64'd0);
    check("rst_count", 64'(beat_count), 64'd0);
    check("rst_err",   64'(err_illegal), 64'd0);
    check("rst_addr",  64'(c1tx_addr), 64'd0);
    req_valid = '0;
    SoftReset = 1'b0;
    step();

    // single 1CL write
    set_req(0, 4'd0, 2'd0, 42'h100, 16'h12);
    ready_is("s1_ready", 4'b0001);
    step();
    req_valid = '0;
    out_is("s1", 2'd0, 2'd0, 42'h100);
    check("s1_type",  64'(c1tx_type), 64'd0);
    check("s1_mdata", 64'(c1tx_mdata), 64'h12);
    check("s1_data",  c1tx_data[63:0], 64'h12);
    check("s1_count", 64'(beat_count), 64'd1);
    step();
    check("s1_idle", 64'(c1tx_valid), 64'd0);

    // 4CL burst from req1 while req2 waits; rr_ptr is 1 here
    set_req(1, 4'd1, 2'd3, 42'h200, 16'h21);
    set_req(2, 4'd0, 2'd0, 42'h300, 16'h31);
    ready_is("b_ready0", 4'b0010);
    step();
    out_is("b0", 2'd1, 2'd0, 42'h200);
    check("b0_len", 64'(c1tx_cl_len), 64'd3);
    set_req(1, 4'd0, 2'd0, 42'hDEAD, 16'h22);
    for (int b = 1; b < 4; b++) begin
      ready_is($sformatf("b_ready%0d", b), 4'b0010);
      step();
      out_is($sformatf("b%0d", b), 2'd1, 2'(b), 42'h200);
      check($sformatf("b%0d_type", b), 64'(c1tx_type), 64'd1);
    end
    ready_is("b_ready_r2", 4'b0100);
    step();
    out_is("b_r2", 2'd2, 2'd0, 42'h300);
    ready_is("b_ready_rr3", 4'b0010);
    step();
    out_is("b_r1", 2'd1, 2'd0, 42'hDEAD);
    req_valid = '0;
    step();

    // mid-burst back-pressure; park rr_ptr at 0 via a lone req3 beat
    set_req(3, 4'd0, 2'd0, 42'h700, 16'h71);
    step();
    set_req(0, 4'd0, 2'd1, 42'h400, 16'h41);
    ready_is("bp_ready0", 4'b0001);
    step();
    out_is("bp0", 2'd0, 2'd0, 42'h400);
    c1TxAlmFull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ready_is($sformatf("bp_full%0d", c), 4'b0000);
      step();
      check($sformatf("bp_idle%0d", c), 64'(c1tx_valid), 64'd0);
    end
    c1TxAlmFull = 1'b0;
    ready_is("bp_ready1", 4'b0001);
    step();
    out_is("bp1", 2'd0, 2'd1, 42'h400);
    req_valid[0] = 1'b0;
    ready_is("bp_ready3", 4'b1000);
    step();
    out_is("bp3", 2'd3, 2'd0, 42'h700);
    req_valid = '0;
    step();

    // fairness over 100 beats, rr_ptr is 0 here
    for (int i = 0; i < NUM_REQ; i++) begin
      gcount[i] = 0;
      set_req(i, 4'd0, 2'd0, ADDR_W'(i * 16), 16'(i));
    end
    for (int k = 0; k < 100; k++) begin
      step();
      if (k == 99) req_valid = '0;
      check($sformatf("fair_gid%0d", k), 64'(c1tx_grant_id), 64'(k % 4));
      if (c1tx_valid) gcount[c1tx_grant_id]++;
    end
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("fair_share%0d", i), 64'(gcount[i]), 64'd25);
    check("fair_count", 64'(beat_count), 64'd111);
    step();

    // illegal cl_len then WrFence with cl_len=3
    set_req(0, 4'd0, 2'd2, 42'h500, 16'h51);
    ready_is("il_ready", 4'b0001);
    step();
    out_is("il", 2'd0, 2'd0, 42'h500);
    check("il_err", 64'(err_illegal), 64'd1);
    check("il_len", 64'(c1tx_cl_len), 64'd0);
    set_req(0, 4'd4, 2'd3, 42'h510, 16'h52);
    ready_is("fn_ready", 4'b0001);
    step();
    req_valid = '0;
    out_is("fn", 2'd0, 2'd0, 42'h510);
    check("fn_err",  64'(err_illegal), 64'd0);
    check("fn_type", 64'(c1tx_type), 64'd4);
    set_req(1, 4'd0, 2'd0, 42'h520, 16'h53);
    ready_is("fn_unlocked", 4'b0010);
    step();
    req_valid = '0;
    out_is("fn_next", 2'd1, 2'd0, 42'h520);
    check("fn_err2", 64'(err_illegal), 64'd0);
    step();

    // reset mid-burst; rr_ptr is 2 here
    set_req(2, 4'd0, 2'd3, 42'h600, 16'h61);
    step();
    step();
    out_is("rb1", 2'd2, 2'd1, 42'h600);
    SoftReset = 1'b1;
    ready_is("rb_rst_ready", 4'b0000);
    step();
    check("rb_valid", 64'(c1tx_valid), 64'd0);
    check("rb_count", 64'(beat_count), 64'd0);
    check("rb_addr",  64'(c1tx_addr), 64'd0);
    SoftReset = 1'b0;
    req_valid[2] = 1'b0;
    set_req(1, 4'd0, 2'd0, 42'h800, 16'h81);
    set_req(3, 4'd0, 2'd0, 42'h900, 16'h91);
    ready_is("rb_new_ready", 4'b0010);
    step();
    req_valid = '0;
    out_is("rb_new", 2'd1, 2'd0, 42'h800);
    check("rb_new_count", 64'(beat_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccip_c1tx_arbiter.md
# ccip_c1tx_arbiter

Round-robin arbiter that shares the CCI-P C1 Tx (AFU→memory write) channel among NUM_REQ requesters. It keeps multi-CL write bursts contiguous, honours the channel almost-full back-pressure, and drives one registered output stage onto the C1 Tx channel. Transaction loggers observe the output stage, so every C1 Tx beat they record was scheduled here.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 42, request address width
- DATA_W, 512, cache-line data width
- clk  in  1  channel clock; all logic on rising edge
- SoftReset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i presents a beat
- req_type  in  4*NUM_REQ  per requester: 0=WrLine_I, 1=WrLine_M, 4=WrFence, 6=Intr; other codes illegal
- req_cl_len  in  2*NUM_REQ  burst length: 0=1CL, 1=2CL, 3=4CL, 2=illegal
- req_addr  in  ADDR_W*NUM_REQ  line address; used only on the first beat of a burst
- req_mdata  in  16*NUM_REQ  metadata tag
- req_data  in  DATA_W*NUM_REQ  write data
- req_ready  out  NUM_REQ  beat accepted from requester i when req_valid[i]&req_ready[i]
- c1TxAlmFull  in  1  channel almost-full
- c1tx_valid  out  1  registered request valid
- c1tx_type, c1tx_cl_len, c1tx_cl_num, c1tx_addr, c1tx_mdata, c1tx_data  out  4/2/2/ADDR_W/16/DATA_W  registered request fields; c1tx_cl_num is the beat index inside the burst
- c1tx_grant_id  out  $clog2(NUM_REQ)  source requester of the current output beat
- err_illegal  out  1  one-cycle pulse when an illegal type or cl_len is accepted
- beat_count  out  32  total beats issued since reset; wraps modulo 2^32

## Operation
- The arbiter has two states: ARB and LOCK.
- **ARB state**
  - If c1TxAlmFull=0, grant the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - Assert req_ready for the granted requester only, in the same cycle (combinational).
  - Burst beats = cl_len+1 for cl_len 0, 1 and 3.
  - WrFence and Intr are 1 beat regardless of cl_len.
  - cl_len=2 or an illegal type: forward the beat as 1CL and pulse err_illegal.
- **ARB → LOCK**: on acceptance of the first beat of a burst with beats>1. Record lock_id and remaining=beats-1.
- **LOCK state**
  - Only lock_id may have req_ready=1, and only while c1TxAlmFull=0.
  - Other requesters are blocked.
  - Each accepted beat decrements remaining and increments beat index.
  - The requester's cl_len, type and addr on beats after the first are ignored; the first-beat values are held.
  - If remaining reaches 0, return to ARB.
- **rr_ptr update**: set to (completing requester + 1) mod NUM_REQ when a burst completes, including 1-beat bursts. It does not change otherwise.
- **Output stage**
  - An accepted beat loads the output registers at the next edge and sets c1tx_valid=1.
  - If no beat is accepted, c1tx_valid=0 and the data fields hold their previous values.
  - beat_count increments for every cycle with c1tx_valid=1.

## Timing
- Reset values:
  - c1tx_valid=0, all c1tx_* fields=0, c1tx_grant_id=0.
  - err_illegal=0, beat_count=0.
  - state=ARB, rr_ptr=0, req_ready=0 during reset.
- Latency: a beat accepted in cycle N appears on c1tx_valid in cycle N+1. Throughput is 1 beat per cycle.
- c1TxAlmFull=1 forces req_ready=0 in the same cycle. The following cycle then has c1tx_valid=0.
- A burst paused by c1TxAlmFull or by req_valid=0 mid-burst stays in LOCK indefinitely. No other requester is granted.
- SoftReset asserted mid-burst: state→ARB, the burst is abandoned, and the output is cleared at the next edge. Reset dominates everything else.
- A requester deasserting req_valid in ARB without acceptance loses nothing; arbitration is re-evaluated every cycle.
- err_illegal is registered and aligned with the offending beat's c1tx_valid.

## Test plan
- **Single 1CL write:** req0 WrLine_I, addr 0x100, mdata 0x12 → req_ready[0]=1 in the same cycle. Next cycle: c1tx_valid=1, type=0, cl_num=0, addr=0x100, beat_count=1.
- **4CL burst with contention:** req1 4CL and req2 1CL both valid → the output shows req1 beats with cl_num 0,1,2,3 back-to-back, then req2. rr_ptr=2 after req1, 3 after req2.
- **Mid-burst back-pressure:** req0 2CL, c1TxAlmFull=1 after beat 0 for 3 cycles, req3 valid throughout → 3 idle output cycles, then req0 beat 1. req3 is granted only afterwards.
- **Fairness:** all 4 requesters continuously valid with 1CL → the grant sequence is 0,1,2,3,0,1… and each requester gets exactly 25% of 100 beats.
- **Illegal and fence:** req0 cl_len=2, then a WrFence with cl_len=3 → both issued as 1 beat. err_illegal pulses once, with the first beat only.
- **Reset mid-burst:** SoftReset asserted after beat 1 of a 4CL burst → the next cycle has c1tx_valid=0 and beat_count=0. A new burst from another requester is granted from rr_ptr=0.
